// File: rtl/mini_seq_ctrl.sv
// mini_seq_ctrl: fetch/execute micro-sequencer driving the datapath_mini control inputs.
// Optional single-step ports are enabled by defining MINI_SEQ_STEP_EN.
package alu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_OR  = 3'd3,
        ALU_AND = 3'd4
    } alu_op_t;
endpackage

module mini_seq_ctrl
    import alu_pkg::*;
#(
    parameter int IMEM_DEPTH = 16,
    parameter int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_wdata,
    input  logic [AW:0]   prog_len,
    input  logic          start,
`ifdef MINI_SEQ_STEP_EN
    input  logic          step_mode,
    input  logic          step,
`endif
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] pc,
    output logic [4:0]    rs1,
    output logic [4:0]    rs2,
    output logic [4:0]    ws,
    output logic          reg_write,
    output alu_op_t       alu_op
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(IMEM_DEPTH);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    logic [31:0]   imem [IMEM_DEPTH];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [31:0]   instr_q, instr_d;
    logic [4:0]    rs1_q, rs1_d;
    logic [4:0]    rs2_q, rs2_d;
    logic [4:0]    ws_q, ws_d;
    logic          reg_write_q, reg_write_d;
    alu_op_t       alu_op_q, alu_op_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          step_go;
    logic [31:0]   fetch_word;

    function automatic logic dec_ok(input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        if (w[6:0] == 7'b0110011) begin
            case ({w[31:25], w[14:12]})
                {7'b0000000, 3'b000}: ok = 1'b1;
                {7'b0100000, 3'b000}: ok = 1'b1;
                {7'b0000000, 3'b100}: ok = 1'b1;
                {7'b0000000, 3'b110}: ok = 1'b1;
                {7'b0000000, 3'b111}: ok = 1'b1;
                default:              ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic alu_op_t dec_op(input logic [31:0] w);
        alu_op_t op;
        op = ALU_ADD;
        case ({w[31:25], w[14:12]})
            {7'b0100000, 3'b000}: op = ALU_SUB;
            {7'b0000000, 3'b100}: op = ALU_XOR;
            {7'b0000000, 3'b110}: op = ALU_OR;
            {7'b0000000, 3'b111}: op = ALU_AND;
            default:              op = ALU_ADD;
        endcase
        return op;
    endfunction

`ifdef MINI_SEQ_STEP_EN
    assign step_go = !step_mode || step;
`else
    assign step_go = 1'b1;
`endif

    assign fetch_word = imem[pc_q];

    // Program buffer is only writable while idle; it has no reset.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == S_IDLE)) begin
            imem[prog_addr] <= prog_wdata;
        end
    end

    // Decoded controls are registered on the FETCH->EXEC edge so that
    // reg_write is high throughout EXEC and commits on the edge ending it.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        instr_d     = instr_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        ws_d        = ws_q;
        alu_op_d    = alu_op_q;
        reg_write_d = 1'b0;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (prog_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = '0;
                        len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                    end
                end
            end
            S_FETCH: begin
                if (step_go) begin
                    instr_d = fetch_word;
                    rs1_d   = fetch_word[19:15];
                    rs2_d   = fetch_word[24:20];
                    ws_d    = fetch_word[11:7];
                    state_d = S_EXEC;
                    if (dec_ok(fetch_word)) begin
                        alu_op_d    = dec_op(fetch_word);
                        reg_write_d = (fetch_word[11:7] != 5'd0);
                    end
                end
            end
            S_EXEC: begin
                if (!dec_ok(instr_q)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if ({1'b0, pc_q} == (len_q - ONE_L)) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            instr_q     <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            ws_q        <= '0;
            alu_op_q    <= ALU_ADD;
            reg_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            instr_q     <= instr_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            ws_q        <= ws_d;
            alu_op_q    <= alu_op_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pc        = pc_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign ws        = ws_q;
    assign reg_write = reg_write_q;
    assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_mini_seq_ctrl.sv
// tb_mini_seq_ctrl: directed bench for mini_seq_ctrl with a small
// register-file/ALU model standing in for datapath_mini.
module tb_mini_seq_ctrl;
    import alu_pkg::*;

    localparam int AW = 4;

    localparam logic [31:0] I_ADD3  = 32'h002081B3;
    localparam logic [31:0] I_SUB4  = 32'h40110233;
    localparam logic [31:0] I_XOR5  = 32'h0020C2B3;
    localparam logic [31:0] I_AND6  = 32'h0020F333;
    localparam logic [31:0] I_ADDI  = 32'h00000013;
    localparam logic [31:0] I_ADDX0 = 32'h00208033;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0]   prog_wdata = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
`ifdef MINI_SEQ_STEP_EN
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
`endif
    logic          busy, done, err, reg_write;
    logic [AW-1:0] pc;
    logic [4:0]    rs1, rs2, ws;
    alu_op_t       alu_op;

    logic [31:0]   rf [32];
    logic          bd_we = 1'b0;
    logic [4:0]    bd_addr = '0;
    logic [31:0]   bd_data = '0;
    int            wr_cnt = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc;
    int            w0;

    mini_seq_ctrl #(.IMEM_DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .prog_len   (prog_len),
        .start      (start),
`ifdef MINI_SEQ_STEP_EN
        .step_mode  (step_mode),
        .step       (step),
`endif
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pc         (pc),
        .rs1        (rs1),
        .rs2        (rs2),
        .ws         (ws),
        .reg_write  (reg_write),
        .alu_op     (alu_op)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input alu_op_t op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            ALU_OR:  return a | b;
            ALU_AND: return a & b;
            default: return a + b;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bd_we) begin
            rf[bd_addr] <= bd_data;
        end else if (reg_write && ws != 5'd0) begin
            rf[ws] <= alu(alu_op, rf[rs1], rf[rs2]);
        end
        if (reg_write) begin
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke_rf(input logic [4:0] a, input logic [31:0] d);
        bd_we = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_wdata = d;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    // Returns the cycle (start edge opens cycle 1) in which done is seen.
    task automatic run(input logic [AW:0] len, input bit poke, output int c);
        prog_len = len;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 1;
        while (!done && c < 60) begin
            if (poke && c == 2) begin
                start = 1'b1;
                prog_we = 1'b1;
                prog_addr = '0;
                prog_wdata = 32'h402081B3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            prog_we = 1'b0;
            c++;
        end
    endtask

    initial begin
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rw", {31'd0, reg_write}, 32'd0);
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_aluop", {29'd0, alu_op}, {29'd0, ALU_ADD});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        poke_rf(5'd1, 32'd10);
        poke_rf(5'd2, 32'd20);
        poke_rf(5'd3, 32'd0);
        load(4'd0, I_ADD3);
        w0 = wr_cnt;
        run(5'd1, 1'b0, cyc);
        chk("t1_cyc", cyc, 3);
        chk("t1_err", {31'd0, err}, 32'd0);
        chk("t1_ws", {27'd0, ws}, 32'd3);
        chk("t1_x3", rf[3], 32'd30);
        chk("t1_wr", wr_cnt - w0, 1);
        @(posedge clk);
        #1;
        chk("t1_busy", {31'd0, busy}, 32'd0);

        load(4'd1, I_SUB4);
        load(4'd2, I_XOR5);
        load(4'd3, I_AND6);
        for (int r = 3; r <= 6; r++) poke_rf(5'(r), 32'hFF);
        w0 = wr_cnt;
        run(5'd4, 1'b0, cyc);
        chk("t2_cyc", cyc, 9);
        chk("t2_x3", rf[3], 32'd30);
        chk("t2_x4", rf[4], 32'd10);
        chk("t2_x5", rf[5], 32'd30);
        chk("t2_x6", rf[6], 32'd0);
        chk("t2_wr", wr_cnt - w0, 4);
        chk("t2_pc", {28'd0, pc}, 32'd3);
        @(posedge clk);
        #1;

        poke_rf(5'd3, 32'hFF);
        run(5'd4, 1'b1, cyc);
        chk("t5_cyc", cyc, 9);
        chk("t5_x3", rf[3], 32'd30);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_idle", {31'd0, busy}, 32'd0);
        poke_rf(5'd3, 32'hFF);
        run(5'd4, 1'b0, cyc);
        chk("t5_slot0", rf[3], 32'd30);
        @(posedge clk);
        #1;

        for (int r = 3; r <= 6; r++) poke_rf(5'(r), 32'd0);
        prog_len = 5'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_rw_pre", {31'd0, reg_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rw", {31'd0, reg_write}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_pc", {28'd0, pc}, 32'd0);
        chk("t6_aluop", {29'd0, alu_op}, {29'd0, ALU_ADD});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_x3", rf[3], 32'd30);
        chk("t6_x4", rf[4], 32'd0);
        chk("t6_x5", rf[5], 32'd0);
        run(5'd4, 1'b0, cyc);
        chk("t6_cyc", cyc, 9);
        chk("t6_x4b", rf[4], 32'd10);
        chk("t6_x6b", rf[6], 32'd0);
        @(posedge clk);
        #1;

        load(4'd1, I_ADDI);
        poke_rf(5'd3, 32'd0);
        poke_rf(5'd5, 32'd0);
        w0 = wr_cnt;
        run(5'd3, 1'b0, cyc);
        chk("t3_cyc", cyc, 5);
        chk("t3_err", {31'd0, err}, 32'd1);
        chk("t3_pc", {28'd0, pc}, 32'd1);
        chk("t3_wr", wr_cnt - w0, 1);
        chk("t3_x3", rf[3], 32'd30);
        chk("t3_x5", rf[5], 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_sticky", {31'd0, err}, 32'd1);

        w0 = wr_cnt;
        run(5'd0, 1'b0, cyc);
        chk("t4_cyc", cyc, 1);
        chk("t4_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_done", {31'd0, done}, 32'd0);
        chk("t4_wr", wr_cnt - w0, 0);

        load(4'd0, I_ADDX0);
        w0 = wr_cnt;
        run(5'd1, 1'b0, cyc);
        chk("x0_cyc", cyc, 3);
        chk("x0_wr", wr_cnt - w0, 0);
        chk("x0_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
